mastermind_codebreaker: RTL and testbench

// - Automatic codebreaker: the guessing end of the code/guess/red-white protocol scored by the datapath.
// - Issues 4-digit guesses (3-bit digits), accepts red/white feedback for each one and stores guess+feedback history.
// - Next guess = lowest candidate (ascending from last issued guess) consistent with every stored entry.
// - Sits opposite the scorer; the top level or bench ties guess/feedback between them.

---
 rtl/mastermind_codebreaker_if.sv | 29 ++
 rtl/mastermind_codebreaker.sv | 174 +++++++++++++++++
 tb/tb_mastermind_codebreaker.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mastermind_codebreaker_if.sv
// Guess/feedback handshake and status bundle
// between the codebreaker and its scorer/driver.
interface mastermind_codebreaker_if;
  logic        start;
  logic [11:0] guess;
  logic        guess_valid;
  logic        guess_ready;
  logic        fb_valid;
  logic [2:0]  fb_red;
  logic [2:0]  fb_white;
  logic        busy;
  logic        solved;
  logic        failed;
  logic [3:0]  guess_count;

  modport master (
    input  start, guess_ready,
    input  fb_valid, fb_red, fb_white,
    output guess, guess_valid,
    output busy, solved, failed, guess_count
  );

  modport slave (
    output start, guess_ready,
    output fb_valid, fb_red, fb_white,
    input  guess, guess_valid,
    input  busy, solved, failed, guess_count
  );
endinterface

// File: rtl/mastermind_codebreaker.sv
// Mastermind codebreaker: issues the lowest candidate
// consistent with all stored guess/feedback entries.
module mastermind_codebreaker #(
  parameter int MAX_GUESSES = 10
) (
  input  logic clk,
  input  logic resetn,
  mastermind_codebreaker_if.master cb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_ISSUE,
    S_WAIT_FB,
    S_WIN,
    S_FAIL
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_GUESSES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_guess;
  logic [11:0] r_cand;
  logic [3:0]  r_j;
  logic [3:0]  r_hist_cnt;
  logic [3:0]  r_guess_count;
  logic [11:0] r_hist_g [MAX_GUESSES];
  logic [2:0]  r_hist_r [MAX_GUESSES];
  logic [2:0]  r_hist_w [MAX_GUESSES];

  logic [11:0] w_hg;
  logic [2:0]  w_red;
  logic [2:0]  w_white;
  logic [2:0]  w_total;
  logic [2:0]  w_ca;
  logic [2:0]  w_cb;
  logic        w_consistent;
  logic        w_empty;
  logic        w_last;
  logic        w_accept;

  // Score the candidate against history entry j
  always_comb begin
    w_hg    = r_hist_g[r_j];
    w_red   = '0;
    w_total = '0;
    w_ca    = '0;
    w_cb    = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_cand[3*k +: 3] == w_hg[3*k +: 3])
        w_red = w_red + 3'd1;
    end
    for (int c = 0; c < 8; c++) begin
      w_ca = '0;
      w_cb = '0;
      for (int k = 0; k < 4; k++) begin
        if (r_cand[3*k +: 3] == 3'(c))
          w_ca = w_ca + 3'd1;
        if (w_hg[3*k +: 3] == 3'(c))
          w_cb = w_cb + 3'd1;
      end
      w_total = w_total + ((w_ca < w_cb) ? w_ca : w_cb);
    end
    w_white      = w_total - w_red;
    w_consistent = (w_red == r_hist_r[r_j]) &&
                   (w_white == r_hist_w[r_j]);
  end

  assign w_empty  = (r_hist_cnt == 4'd0);
  assign w_last   = (r_j == r_hist_cnt - 4'd1);
  assign w_accept = (r_state == S_ISSUE) &&
                    cb.guess_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decision
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_WIN, S_FAIL: begin
        if (cb.start) w_state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        if (w_empty)
          w_state_nxt = S_ISSUE;
        else if (!w_consistent) begin
          if (r_cand == 12'hFFF)
            w_state_nxt = S_FAIL;
        end else if (w_last)
          w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (cb.guess_ready) w_state_nxt = S_WAIT_FB;
      end
      S_WAIT_FB: begin
        if (cb.fb_valid) begin
          if (cb.fb_red == 3'd4)
            w_state_nxt = S_WIN;
          else if (r_guess_count == LP_MAX)
            w_state_nxt = S_FAIL;
          else if (r_guess == 12'hFFF)
            w_state_nxt = S_FAIL;
          else
            w_state_nxt = S_SEARCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Candidate search, issue and history datapath
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_guess       <= '0;
      r_cand        <= '0;
      r_j           <= '0;
      r_hist_cnt    <= '0;
      r_guess_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_WIN, S_FAIL: begin
          if (cb.start) begin
            r_cand        <= '0;
            r_j           <= '0;
            r_hist_cnt    <= '0;
            r_guess_count <= '0;
          end
        end
        S_SEARCH: begin
          if (w_empty || (w_consistent && w_last)) begin
            r_guess <= r_cand;
          end else if (!w_consistent) begin
            if (r_cand != 12'hFFF)
              r_cand <= r_cand + 12'd1;
            r_j <= '0;
          end else begin
            r_j <= r_j + 4'd1;
          end
        end
        S_ISSUE: begin
          if (w_accept)
            r_guess_count <= r_guess_count + 4'd1;
        end
        S_WAIT_FB: begin
          if (cb.fb_valid) begin
            r_hist_g[r_guess_count - 4'd1] <= r_guess;
            r_hist_r[r_guess_count - 4'd1] <= cb.fb_red;
            r_hist_w[r_guess_count - 4'd1] <= cb.fb_white;
            r_hist_cnt <= r_hist_cnt + 4'd1;
            r_cand     <= r_guess + 12'd1;
            r_j        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cb.guess       = r_guess;
  assign cb.guess_valid = (r_state == S_ISSUE);
  assign cb.busy        = (r_state == S_SEARCH) ||
                          (r_state == S_ISSUE) ||
                          (r_state == S_WAIT_FB);
  assign cb.solved      = (r_state == S_WIN);
  assign cb.failed      = (r_state == S_FAIL);
  assign cb.guess_count = r_guess_count;

endmodule

// File: tb/tb_mastermind_codebreaker.sv
// Bench for mastermind_codebreaker: directed games
// plus random secrets against a brute-force solver model.
module tb_mastermind_codebreaker;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mastermind_codebreaker_if a_if ();
  mastermind_codebreaker_if b_if ();

  mastermind_codebreaker #(.MAX_GUESSES(15)) dut_a (
    .clk(clk), .resetn(resetn), .cb(a_if.master)
  );
  mastermind_codebreaker #(.MAX_GUESSES(1)) dut_b (
    .clk(clk), .resetn(resetn), .cb(b_if.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] hg [$];
  logic [5:0]  hs [$];
  logic [11:0] og [$];
  int          first_wait;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int dig(input logic [11:0] v, input int k);
    return int'((v >> (3 * k)) & 12'd7);
  endfunction

  // Reference score: {red, white}
  function automatic logic [5:0] ref_score(input logic [11:0] a,
                                           input logic [11:0] b);
    int ca [8];
    int cb [8];
    int red;
    int tot;
    red = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin
      ca[c] = 0;
      cb[c] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      if (dig(a, k) == dig(b, k)) red++;
      ca[dig(a, k)]++;
      cb[dig(b, k)]++;
    end
    for (int c = 0; c < 8; c++)
      tot += (ca[c] < cb[c]) ? ca[c] : cb[c];
    return {3'(red), 3'(tot - red)};
  endfunction

  // Lowest candidate >= from consistent with history, or -1
  function automatic int ref_next(input int from);
    bit ok;
    for (int c = from; c < 4096; c++) begin
      ok = 1'b1;
      for (int i = 0; i < hg.size(); i++)
        if (ref_score(12'(c), hg[i]) != hs[i]) ok = 1'b0;
      if (ok) return c;
    end
    return -1;
  endfunction

  task automatic pulse_start_a();
    @(negedge clk) a_if.start = 1'b1;
    @(negedge clk) a_if.start = 1'b0;
  endtask

  // Play one full game on dut_a against a secret
  task automatic play(input logic [11:0] secret);
    int from;
    int exp;
    int cyc;
    logic [5:0] sc;
    hg.delete();
    hs.delete();
    og.delete();
    from = 0;
    pulse_start_a();
    for (int t = 0; t < 15; t++) begin
      exp = ref_next(from);
      cyc = 0;
      while (!a_if.guess_valid && !a_if.failed && cyc < 6000) begin
        @(negedge clk);
        cyc++;
      end
      if (t == 0) first_wait = cyc;
      if (exp < 0) begin
        check("exhaust_failed", 32'(a_if.failed), 32'd1);
        return;
      end
      check("guess_valid", 32'(a_if.guess_valid), 32'd1);
      if (!a_if.guess_valid) return;
      check("guess", 32'(a_if.guess), 32'(exp));
      og.push_back(a_if.guess);
      a_if.guess_ready = 1'b1;
      @(negedge clk) a_if.guess_ready = 1'b0;
      check("count", 32'(a_if.guess_count), 32'(t + 1));
      sc = ref_score(12'(exp), secret);
      hg.push_back(12'(exp));
      hs.push_back(sc);
      a_if.fb_valid = 1'b1;
      a_if.fb_red   = sc[5:3];
      a_if.fb_white = sc[2:0];
      @(negedge clk) a_if.fb_valid = 1'b0;
      if (sc[5:3] == 3'd4) begin
        check("solved", 32'(a_if.solved), 32'd1);
        check("not_failed", 32'(a_if.failed), 32'd0);
        check("idle_busy", 32'(a_if.busy), 32'd0);
        return;
      end
      from = exp + 1;
    end
    check("too_many_guesses", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    logic [11:0] held;
    logic [11:0] sec;
    a_if.start = 0; a_if.guess_ready = 0;
    a_if.fb_valid = 0; a_if.fb_red = 0; a_if.fb_white = 0;
    b_if.start = 0; b_if.guess_ready = 0;
    b_if.fb_valid = 0; b_if.fb_red = 0; b_if.fb_white = 0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    check("rst_guess", 32'(a_if.guess), 32'd0);
    check("rst_valid", 32'(a_if.guess_valid), 32'd0);
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_solved", 32'(a_if.solved), 32'd0);
    check("rst_failed", 32'(a_if.failed), 32'd0);
    check("rst_count", 32'(a_if.guess_count), 32'd0);

    // Secret 0000
    play(12'h000);
    check("t1_latency", 32'(first_wait <= 2), 32'd1);
    check("t1_count", 32'(a_if.guess_count), 32'd1);

    // Secret 7777
    play(12'hFFF);
    check("t2_nguess", 32'(og.size()), 32'd8);
    if (og.size() >= 2)
      check("t2_second", 32'(og[1]), 32'h249);
    if (og.size() >= 1)
      check("t2_last", 32'(og[og.size() - 1]), 32'hFFF);

    // Random secrets
    for (int g = 0; g < 14; g++) begin
      sec = 12'($urandom_range(0, 4095));
      play(sec);
    end

    // Inconsistent feedback exhausts the search
    pulse_start_a();
    cyc = 0;
    while (!a_if.guess_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_guess", 32'(a_if.guess), 32'h000);
    a_if.guess_ready = 1'b1;
    @(negedge clk) a_if.guess_ready = 1'b0;
    a_if.fb_valid = 1'b1;
    a_if.fb_red = 3'd3;
    a_if.fb_white = 3'd1;
    @(negedge clk) a_if.fb_valid = 1'b0;
    cyc = 0;
    while (!a_if.failed && !a_if.guess_valid && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_failed", 32'(a_if.failed), 32'd1);
    check("t4_cycles", 32'(cyc > 4000), 32'd1);
    check("t4_count", 32'(a_if.guess_count), 32'd1);
    check("t4_busy", 32'(a_if.busy), 32'd0);

    // Single-guess budget on dut_b, secret 1234
    @(negedge clk) b_if.start = 1'b1;
    @(negedge clk) b_if.start = 1'b0;
    cyc = 0;
    while (!b_if.guess_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_guess", 32'(b_if.guess), 32'h000);
    b_if.guess_ready = 1'b1;
    @(negedge clk);
    sec = {3'd1, 3'd2, 3'd3, 3'd4};
    b_if.fb_valid = 1'b1;
    b_if.fb_red = ref_score(12'h000, sec) >> 3;
    b_if.fb_white = ref_score(12'h000, sec) & 6'd7;
    @(negedge clk) b_if.fb_valid = 1'b0;
    check("t5_failed", 32'(b_if.failed), 32'd1);
    check("t5_count", 32'(b_if.guess_count), 32'd1);
    cyc = 0;
    repeat (10) begin
      @(negedge clk);
      if (b_if.guess_valid) cyc++;
    end
    b_if.guess_ready = 1'b0;
    check("t5_no_second", 32'(cyc), 32'd0);

    // Back-pressure, then reset mid-WAIT_FB
    pulse_start_a();
    cyc = 0;
    while (!a_if.guess_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    held = a_if.guess;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_hold", 32'({a_if.guess_valid, a_if.guess}),
            32'({1'b1, held}));
    end
    a_if.guess_ready = 1'b1;
    @(negedge clk) a_if.guess_ready = 1'b0;
    check("t6_waitfb", 32'({a_if.busy, a_if.guess_valid}),
          32'b10);
    resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
    check("t6_rst_outs",
          32'({a_if.guess, a_if.guess_valid, a_if.busy,
               a_if.solved, a_if.failed, a_if.guess_count}),
          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
